sha_w_sched: RTL and testbench
==============================

Name: sha_w_sched

Overview:
- Parametrised SHA-256 message-schedule stage for the bitcoin_miner pipeline.
- Loads a 512-bit block in one cycle and expands it to ROUNDS words at LANES words per cycle.
- Carries a sideband (nonce + chaining H) alongside the block.
- Uses a ready/valid handshake on both sides, so it sits between the nonce/block generator and the compression rounds with backpressure.

Parameters:
- WORD_S, 32, schedule word width; only 32 is supported (SHA-256 sig functions).
- ROUNDS, 64, number of W words produced; legal range 17..64, with (ROUNDS-16) % LANES == 0.
- LANES, 1, words computed per expansion cycle; legal values 1, 2, 4.
- SB_W, 288, sideband width (nonce 32 + H 256), passed through untouched.

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, M/sb_in valid.
- in_ready, out, 1, block can accept.
- M, in, 16*WORD_S, message block; word 0 in the MSBs.
- sb_in, in, SB_W, sideband in.
- flush, in, 1, synchronous abort to IDLE.
- out_valid, out, 1, W/sb_out valid.
- out_ready, in, 1, consumer accepts.
- W, out, ROUNDS*WORD_S, schedule; word i at bits [i*WORD_S +: WORD_S].
- sb_out, out, SB_W, sideband captured with the block.
- busy, out, 1, high in EXPAND.

Behaviour:
- Reset (reset_n low, async):
  - State goes to IDLE.
  - W, sb_out, out_valid, busy and the internal count all clear to 0.
  - Takes effect mid-expansion as well; the partial result is discarded.
- States: IDLE, EXPAND, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This combinational path is intended and allows back-to-back blocks.
  - out_valid = (state==DONE). busy = (state==EXPAND).
- Accept (in_valid & in_ready at edge k):
  - W[0..15] are loaded from M in one cycle; word i = M[(16-i)*WORD_S-1 -: WORD_S].
  - W[16..ROUNDS-1] are cleared.
  - sb_out <= sb_in; count <= 16; state goes to EXPAND.
- EXPAND, each edge:
  - For j in 0..LANES-1, t = count+j: W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], mod 2^32.
  - For LANES=4, lanes 2 and 3 take W[t-2] combinationally from lanes 0 and 1 of the same cycle.
  - count += LANES.
  - When count+LANES == ROUNDS, state goes to DONE on that edge.
- Latency: accept edge k; out_valid goes high after edge k+(ROUNDS-16)/LANES.
  - Defaults: 48 cycles.
  - LANES=4: 12 cycles.
- DONE:
  - W and sb_out are held stable while out_valid & !out_ready.
  - On out_ready: if in_valid, load the new block (same edge); else go to IDLE.
- flush (synchronous):
  - Forces IDLE with out_valid 0 and no output transfer.
  - Overrides a simultaneous accept.
  - W contents are don't-care after flush; sb_out is unchanged.
- Inputs in EXPAND are ignored (in_ready is 0). in_valid may stay high; the block is taken on a later in_ready.
- count is 7 bits, wide enough for 64, and never wraps.

Decomposition:
- Shared sha.vh: WORD_S, `sig0`/`sig1` macros, MSG_BLKCNT=16. Reuse these; add no new rotation macros.
- Sub-module sha_w_word: combinational, 4 word inputs to 1 word output. It implements the schedule recurrence and is instantiated LANES times.
- FSM, count and W register file live in sha_w_sched.

Test Plan:
- "abc" padded block, M = 0x61626380 followed by 0x0 words, last word 0x00000018; defaults:
  - out_valid exactly 48 cycles after accept.
  - W[16]=0x61626380, W[17]=0x000F0000.
  - W[18..63] match the C reference model.
- Same block with LANES=2 and LANES=4:
  - Identical W.
  - out_valid after 24 and 12 cycles respectively.
- All-zero M, sb_in=0xDEADBEEF in the low bits:
  - All 64 W words are 0.
  - sb_out low bits = 0xDEADBEEF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with a second block pending:
  - W stable and in_ready=0 throughout.
  - On out_ready=1, the second block is accepted on the same edge.
  - Its out_valid arrives 48 cycles later.
- reset_n pulsed low mid-EXPAND (cycle 20) → outputs are 0 immediately and asynchronously; after release the next block completes normally.
- flush asserted at cycle 5 of EXPAND, simultaneous with in_valid → returns to IDLE with no out_valid; the next block accepted afterwards yields correct W.

Source files
------------

// File: rtl/sha_w_sched_pkg.sv
// ---------------------------------------------------------------------------
// sha_w_sched_pkg
// Shared SHA-256 message-schedule definitions: word width, block word count,
// the schedule FSM state type and the two small-sigma functions used by the
// W-recurrence.
// ---------------------------------------------------------------------------
package sha_w_sched_pkg;

    localparam int SHA_WORD_S = 32;  // SHA-256 word width
    localparam int MSG_BLKCNT = 16;  // words in one 512-bit message block

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [SHA_WORD_S-1:0] sig0(input logic [SHA_WORD_S-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [SHA_WORD_S-1:0] sig1(input logic [SHA_WORD_S-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_w_word.sv
// ---------------------------------------------------------------------------
// sha_w_word
// Combinational SHA-256 schedule recurrence for one word:
//   w_new = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16   (mod 2^32)
// Ports:
//   w_m2, w_m7, w_m15, w_m16 : W[t-2], W[t-7], W[t-15], W[t-16]
//   w_new                    : W[t]
// ---------------------------------------------------------------------------
module sha_w_word
    import sha_w_sched_pkg::*;
(
    input  logic [SHA_WORD_S-1:0] w_m2,
    input  logic [SHA_WORD_S-1:0] w_m7,
    input  logic [SHA_WORD_S-1:0] w_m15,
    input  logic [SHA_WORD_S-1:0] w_m16,
    output logic [SHA_WORD_S-1:0] w_new
);

    assign w_new = sig1(w_m2) + w_m7 + sig0(w_m15) + w_m16;

endmodule

// File: rtl/sha_w_sched.sv
// ---------------------------------------------------------------------------
// sha_w_sched
// SHA-256 message-schedule stage. Accepts a 512-bit block plus sideband with
// a ready/valid handshake, expands it to ROUNDS words at LANES words per
// cycle and presents the full schedule with the captured sideband.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready, M  : block input (word 0 in the MSBs), sb_in sideband
//   flush                 : synchronous abort back to IDLE
//   out_valid/out_ready   : schedule output handshake
//   W                     : schedule, word i at [i*WORD_S +: WORD_S]
//   sb_out                : sideband captured with the block
//   busy                  : high while expanding
// WORD_S must be 32; ROUNDS in 17..64 with (ROUNDS-16) % LANES == 0;
// LANES in {1,2,4}.
// ---------------------------------------------------------------------------
module sha_w_sched
    import sha_w_sched_pkg::*;
#(
    parameter int WORD_S = 32,
    parameter int ROUNDS = 64,
    parameter int LANES  = 1,
    parameter int SB_W   = 288
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*WORD_S-1:0]     M,
    input  logic [SB_W-1:0]          sb_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROUNDS*WORD_S-1:0] W,
    output logic [SB_W-1:0]          sb_out,
    output logic                     busy
);

    localparam int IDX_W = $clog2(ROUNDS);

    sched_state_e      state_q, state_d;
    logic [6:0]        count_q, count_d;
    logic [SB_W-1:0]   sb_q, sb_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [WORD_S-1:0] w_q [ROUNDS];
    logic [WORD_S-1:0] w_d [ROUNDS];

    logic [WORD_S-1:0] lane_out [LANES];
    logic [IDX_W-1:0]  lane_idx [LANES];
    logic              load;

    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign load     = in_valid & in_ready;

    // Expansion lanes: lane j produces W[count+j]. The index is clamped into
    // the legal range so the lanes read valid registers even outside EXPAND.
    for (genvar j = 0; j < LANES; j++) begin : gen_lane
        logic [IDX_W-1:0]  ti;
        logic [WORD_S-1:0] m2;
        logic [WORD_S-1:0] w_new;

        always_comb begin
            int t;
            t = int'(count_q) + j;
            if (t < MSG_BLKCNT) t = MSG_BLKCNT;
            if (t > ROUNDS - 1) t = ROUNDS - 1;
            ti = IDX_W'(t);
        end

        // With four lanes, W[t-2] for lanes 2/3 is produced this same cycle
        // by lanes 0/1, so it is forwarded instead of read from registers.
        if (j >= 2) begin : gen_fwd
            assign m2 = gen_lane[j-2].w_new;
        end else begin : gen_reg
            assign m2 = w_q[ti - IDX_W'(2)];
        end

        sha_w_word u_word (
            .w_m2  (m2),
            .w_m7  (w_q[ti - IDX_W'(7)]),
            .w_m15 (w_q[ti - IDX_W'(15)]),
            .w_m16 (w_q[ti - IDX_W'(16)]),
            .w_new (w_new)
        );

        assign lane_out[j] = w_new;
        assign lane_idx[j] = ti;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sb_d    = sb_q;
        w_d     = w_q;

        case (state_q)
            ST_EXPAND: begin
                for (int j = 0; j < LANES; j++) begin
                    w_d[lane_idx[j]] = lane_out[j];
                end
                count_d = count_q + 7'(LANES);
                if (count_q + 7'(LANES) == 7'(ROUNDS)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase

        // Accept from IDLE, or from DONE on the same edge the result leaves.
        if (load) begin
            for (int i = 0; i < MSG_BLKCNT; i++) begin
                w_d[i] = M[(16-i)*WORD_S-1 -: WORD_S];
            end
            for (int i = MSG_BLKCNT; i < ROUNDS; i++) begin
                w_d[i] = '0;
            end
            sb_d    = sb_in;
            count_d = 7'(MSG_BLKCNT);
            state_d = ST_EXPAND;
        end

        // flush wins over everything, including a simultaneous accept.
        if (flush) begin
            state_d = ST_IDLE;
            count_d = count_q;
            sb_d    = sb_q;
            w_d     = w_q;
        end

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_EXPAND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            w_q         <= w_d;
        end
    end

    for (genvar i = 0; i < ROUNDS; i++) begin : gen_wout
        assign W[i*WORD_S +: WORD_S] = w_q[i];
    end

    assign sb_out    = sb_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sha_w_sched.sv
// ---------------------------------------------------------------------------
// tb_sha_w_sched
// Self-checking bench for sha_w_sched. Three instances (LANES = 1, 2, 4)
// share the input side; schedules are compared against a behavioural
// SHA-256 message-expansion model.
// ---------------------------------------------------------------------------
module tb_sha_w_sched;

    localparam int WS = 32;
    localparam int RN = 64;
    localparam int SBW = 288;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid, flush, out_ready;
    logic [511:0]   M;
    logic [SBW-1:0] sb_in;

    logic           ir1, ir2, ir4, ov1, ov2, ov4, bz1, bz2, bz4;
    logic [RN*WS-1:0] W1, W2, W4;
    logic [SBW-1:0] sb1, sb2, sb4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_w [64];

    always #5 clk = ~clk;

    sha_w_sched #(.WORD_S(WS), .ROUNDS(RN), .LANES(1), .SB_W(SBW)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
        .M(M), .sb_in(sb_in), .flush(flush), .out_valid(ov1),
        .out_ready(out_ready), .W(W1), .sb_out(sb1), .busy(bz1));

    sha_w_sched #(.WORD_S(WS), .ROUNDS(RN), .LANES(2), .SB_W(SBW)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir2),
        .M(M), .sb_in(sb_in), .flush(flush), .out_valid(ov2),
        .out_ready(out_ready), .W(W2), .sb_out(sb2), .busy(bz2));

    sha_w_sched #(.WORD_S(WS), .ROUNDS(RN), .LANES(4), .SB_W(SBW)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir4),
        .M(M), .sb_in(sb_in), .flush(flush), .out_valid(ov4),
        .out_ready(out_ready), .W(W4), .sb_out(sb4), .busy(bz4));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: FIPS 180-4 message schedule written straight from the text.
    task automatic build_model(input logic [511:0] m);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) exp_w[i] = m[511-32*i -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    task automatic check_w(input string nm, input logic [RN*WS-1:0] w);
        for (int i = 0; i < RN; i++)
            check($sformatf("%s[%0d]", nm, i), 64'(w[i*WS +: WS]), 64'(exp_w[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SBW-1:0] rand_sb();
        logic [SBW-1:0] r;
        for (int i = 0; i < SBW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [511:0] m, input logic [SBW-1:0] sb);
        M = m;
        sb_in = sb;
        check("in_ready_before_accept", 64'(ir1), 64'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", 64'(bz1), 64'd1);
    endtask

    // Wait (bounded) for all three instances to finish and check latencies.
    task automatic wait_all();
        int l1, l2, l4;
        l1 = -1; l2 = -1; l4 = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (ov1 && l1 < 0) l1 = c;
            if (ov2 && l2 < 0) l2 = c;
            if (ov4 && l4 < 0) l4 = c;
            if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
        end
        check("latency_lanes1", 64'(l1), 64'd48);
        check("latency_lanes2", 64'(l2), 64'd24);
        check("latency_lanes4", 64'(l4), 64'd12);
    endtask

    task automatic verify(input logic [511:0] m, input logic [SBW-1:0] sb);
        build_model(m);
        check_w("W_l1", W1);
        check_w("W_l2", W2);
        check_w("W_l4", W4);
        check("sb_l1", sb1[63:0], sb[63:0]);
        check("sb_l1_hi", sb1[SBW-1 -: 64], sb[SBW-1 -: 64]);
        check("sb_l4", sb4[63:0], sb[63:0]);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_release", 64'({ov1, bz1, ir1}), 64'b001);
    endtask

    task automatic run_block(input logic [511:0] m, input logic [SBW-1:0] sb);
        send(m, sb);
        wait_all();
        verify(m, sb);
        release_out();
    endtask

    initial begin
        logic [511:0]     abc, blk_a, blk_b;
        logic [SBW-1:0]   sb_a, sb_b;
        logic [RN*WS-1:0] snap;

        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        M = '0; sb_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'({ov1, ov2, ov4}), 64'd0);
        check("reset_busy", 64'({bz1, bz2, bz4}), 64'd0);
        check("reset_in_ready", 64'(ir1), 64'd1);
        check("reset_W_zero", 64'(|{W1, W2, W4}), 64'd0);
        check("reset_sb_zero", 64'(|{sb1, sb2, sb4}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // "abc" padded block on all lane counts.
        abc = '0;
        abc[511 -: 32] = 32'h61626380;
        abc[31:0]      = 32'h00000018;
        send(abc, rand_sb());
        wait_all();
        check("abc_W16", 64'(W1[16*WS +: WS]), 64'h61626380);
        check("abc_W17", 64'(W1[17*WS +: WS]), 64'h000F0000);
        verify(abc, sb_in);
        release_out();

        // All-zero block with marked sideband.
        sb_a = '0;
        sb_a[31:0] = 32'hDEADBEEF;
        run_block('0, sb_a);
        check("zero_sb_marker", 64'(sb1[31:0]), 64'hDEADBEEF);

        // Random blocks.
        for (int k = 0; k < 4; k++) run_block(rand_blk(), rand_sb());

        // Backpressure with a second block pending.
        blk_a = rand_blk(); sb_a = rand_sb();
        blk_b = rand_blk(); sb_b = rand_sb();
        send(blk_a, sb_a);
        wait_all();
        verify(blk_a, sb_a);
        snap = W1;
        M = blk_b; sb_in = sb_b; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_W_stable", 64'(W1 === snap), 64'd1);
            check("bp_in_ready_low", 64'(ir1), 64'd0);
            check("bp_out_valid_high", 64'(ov1), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_on_out_ready", 64'(ir1), 64'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_second_accepted", 64'({ov1, bz1}), 64'b01);
        wait_all();
        verify(blk_b, sb_b);
        release_out();

        // Asynchronous reset in the middle of expansion.
        send(rand_blk(), rand_sb());
        repeat (19) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_out_valid", 64'({ov1, ov2, ov4}), 64'd0);
        check("areset_busy", 64'(bz1), 64'd0);
        check("areset_W_zero", 64'(|W1), 64'd0);
        check("areset_sb_zero", 64'(|sb1), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_block(rand_blk(), rand_sb());

        // flush at cycle 5 of EXPAND with in_valid high.
        blk_a = rand_blk(); sb_a = rand_sb();
        send(blk_a, sb_a);
        repeat (4) tick();
        check("flush_pre_busy", 64'(bz1), 64'd1);
        M = rand_blk(); sb_in = rand_sb();
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_state", 64'({ov1, bz1, ir1}), 64'b001);
        check("flush_sb_kept", sb1[63:0], sb_a[63:0]);
        repeat (3) tick();
        check("flush_no_out_valid", 64'({ov1, ov2, ov4}), 64'd0);
        run_block(rand_blk(), rand_sb());

        // flush in DONE overrides a same-edge accept.
        send(rand_blk(), rand_sb());
        wait_all();
        M = rand_blk(); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        check("flush_done_l1", 64'({ov1, bz1}), 64'd0);
        check("flush_done_l4", 64'({ov4, bz4}), 64'd0);
        run_block(rand_blk(), rand_sb());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got simulation still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
